instr_loop_sched: RTL and testbench
===================================

Name: instr_loop_sched

Overview:
- Sequencer for the instruction-buffer BRAM.
- Captures a host instruction sequence (terminated by END_ISEQ) into a dual-port BRAM, then replays it to the instruction FIFO N times, or indefinitely until a STOP instruction arrives.
- Owns all BRAM write/read addressing, iteration counting, and FIFO backpressure, using a 2-entry skid buffer to absorb the 1-cycle BRAM read latency.
- Sits between the host command interface and instr_recv/instr FIFOs.

Parameters:
- ADDR_SIZE, 13, BRAM address width; capacity 2**ADDR_SIZE instructions.
- CMD_SIZE, 32, instruction width.
- ITER_W, 16, width of loop_count and iter_cnt.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- app_en  in  1  host instruction valid.
- app_instr  in  CMD_SIZE  host instruction; opcode = [CMD_SIZE-1:CMD_SIZE-4].
- app_ack  out  1  host instruction accepted this cycle.
- loop_count  in  ITER_W  iterations to replay; 0 = infinite. Sampled on IDLE->FILL.
- bram_we  out  1  BRAM port A write enable.
- bram_waddr  out  ADDR_SIZE  BRAM write address.
- bram_wdata  out  CMD_SIZE  BRAM write data (= app_instr).
- bram_re  out  1  BRAM port B read enable.
- bram_raddr  out  ADDR_SIZE  BRAM read address.
- bram_rdata  in  CMD_SIZE  port B data, valid 1 cycle after bram_re.
- out_valid  out  1  replayed instruction valid.
- out_instr  out  CMD_SIZE  replayed instruction.
- out_ready  in  1  FIFO not full.
- looping  out  1  high in REPLAY and DRAIN.
- iter_cnt  out  ITER_W  completed iterations.
- done  out  1  1-cycle pulse when replay finishes.
- overflow  out  1  sticky; program exceeded capacity. Cleared on the next IDLE->FILL.

Behaviour:
- Reset (async assert, sync-release use): state IDLE; wr_ptr, rd_ptr, len, iter_cnt = 0; skid empty; no read in flight; stop_pend = 0. All outputs 0.
- IDLE:
  - On app_en: app_ack=1, bram_we=1 at addr 0, latch loop_count, clear overflow.
  - If the opcode is END_ISEQ: len=1, go REPLAY. Otherwise wr_ptr=1, go FILL.
- FILL:
  - Each app_en: app_ack=1, bram_we=1 at wr_ptr, wr_ptr++.
  - END_ISEQ: len=wr_ptr+1, go REPLAY.
  - Non-END_ISEQ written at address 2**ADDR_SIZE-1: set overflow, go IDLE (program discarded).
  - STOP opcode in FILL is stored like any other instruction.
- REPLAY:
  - Credit rule: issue bram_re at rd_ptr when skid_count + inflight < 2. This guarantees no drop when out_ready is low.
  - Read data enters the skid on the cycle after bram_re. out_valid = skid non-empty; entry pops when out_valid & out_ready. Order preserved.
  - After issuing rd_ptr == len-1: rd_ptr wraps to 0, iter_cnt++.
  - Stop issuing and go DRAIN on that wrap when either (loop_count != 0 and new iter_cnt == loop_count) or stop_pend.
  - Host STOP in REPLAY: app_en with STOP opcode gives app_ack=1 and sets stop_pend. The current iteration completes; STOP is never truncated mid-iteration.
  - Other host instructions in REPLAY get app_ack=0 and are not consumed.
  - STOP coinciding with the final wrap: go DRAIN, single done.
- DRAIN: no new reads. When skid empty and inflight=0: done=1 for one cycle, go IDLE. rd_ptr, stop_pend and iter_cnt are cleared on the IDLE->FILL transition; iter_cnt is held for readback until then.
- app_ack is 0 in DRAIN.
- END_ISEQ is stored and replayed once per iteration; downstream treats it as the transfer boundary.
- Pointer arithmetic is modulo 2**ADDR_SIZE. len ranges over 1..2**ADDR_SIZE and is ADDR_SIZE+1 bits wide.
- iter_cnt saturates at all-ones in infinite mode.

Decomposition:
- Shared package/include (softMC.inc): opcode constants END_ISEQ and STOP, opcode field position, and state encodings IDLE/FILL/REPLAY/DRAIN.
- Sub-module loop_skid_buf: 2-entry FIFO with count output. It is used by the credit rule and is independently verifiable.

Test Plan:
- Load 4 instrs (3 + END_ISEQ) with loop_count=3, out_ready=1 → 12 outputs in order A,B,C,END ×3; iter_cnt=3; one done pulse; looping falls on the cycle after done.
- Same program with out_ready toggling 1/0 every cycle → identical 12-output sequence, no duplicates or drops, never more than 2 reads outstanding.
- loop_count=0; after 5 iterations send STOP mid-iteration → STOP acked; the iteration completes; the output count is a multiple of 4; done pulses once.
- Single END_ISEQ program with loop_count=2 → IDLE goes directly to REPLAY; outputs END,END; done.
- ADDR_SIZE=4 with 16 non-END instrs → overflow=1 after the 16th write; returns to IDLE; no out_valid.
- Assert rst_n low during REPLAY with the skid full → all outputs 0 immediately (async); after release a new program loads from addr 0 correctly.

Source files
------------

// File: rtl/instr_loop_sched_pkg.sv
// Shared definitions for the instruction loop sequencer: opcode field layout,
// the opcodes the sequencer reacts to, and the controller state type.
package instr_loop_sched_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] END_ISEQ = 4'h0;
  localparam logic [OPC_W-1:0] STOP     = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    REPLAY = 2'd2,
    DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_loop_sched_if.sv
// Host, BRAM and instruction-FIFO signals of the loop sequencer.
// The slave side is the sequencer; the master side is its environment.
interface instr_loop_sched_if #(
  parameter int unsigned ADDR_SIZE = 13,
  parameter int unsigned CMD_SIZE  = 32,
  parameter int unsigned ITER_W    = 16
);
  logic                 app_en;
  logic [CMD_SIZE-1:0]  app_instr;
  logic                 app_ack;
  logic [ITER_W-1:0]    loop_count;

  logic                 bram_we;
  logic [ADDR_SIZE-1:0] bram_waddr;
  logic [CMD_SIZE-1:0]  bram_wdata;
  logic                 bram_re;
  logic [ADDR_SIZE-1:0] bram_raddr;
  logic [CMD_SIZE-1:0]  bram_rdata;

  logic                 out_valid;
  logic [CMD_SIZE-1:0]  out_instr;
  logic                 out_ready;

  logic                 looping;
  logic [ITER_W-1:0]    iter_cnt;
  logic                 done;
  logic                 overflow;

  modport master (
    output app_en, app_instr, loop_count, bram_rdata, out_ready,
    input  app_ack, bram_we, bram_waddr, bram_wdata, bram_re, bram_raddr,
           out_valid, out_instr, looping, iter_cnt, done, overflow
  );

  modport slave (
    input  app_en, app_instr, loop_count, bram_rdata, out_ready,
    output app_ack, bram_we, bram_waddr, bram_wdata, bram_re, bram_raddr,
           out_valid, out_instr, looping, iter_cnt, done, overflow
  );

endinterface

// File: rtl/instr_loop_sched_skid.sv
// Two-entry FIFO that catches BRAM read data; its occupancy feeds the
// read-credit decision in the sequencer.
module loop_skid_buf #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_idx;
  logic         rd_idx;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_idx] <= din;
        wr_idx      <= ~wr_idx;
      end
      if (do_pop) rd_idx <= ~rd_idx;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign dout  = mem[rd_idx];
  assign valid = (cnt != 2'd0);
  assign count = cnt;

endmodule

// File: rtl/instr_loop_sched.sv
// Instruction-buffer sequencer: captures a host program into BRAM, then
// replays it to the instruction FIFO a fixed number of times or until STOP.
module instr_loop_sched
  import instr_loop_sched_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 13,
  parameter int unsigned CMD_SIZE  = 32,
  parameter int unsigned ITER_W    = 16
) (
  input logic               clk,
  input logic               rst_n,
  instr_loop_sched_if.slave bus
);

  localparam int unsigned LEN_W = ADDR_SIZE + 1;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [LEN_W-1:0]     len;
  logic [ITER_W-1:0]    iter_cnt;
  logic [ITER_W-1:0]    loop_q;
  logic [ITER_W-1:0]    iter_next;
  logic                 overflow;
  logic                 stop_pend;
  logic                 inflight;

  logic [OPC_W-1:0]     opcode;
  logic                 is_end;
  logic                 is_stop;
  logic                 stop_now;
  logic                 last_rd;
  logic                 reached;
  logic                 credit_ok;

  logic                 app_ack;
  logic                 bram_we;
  logic [ADDR_SIZE-1:0] bram_waddr;
  logic                 bram_re;
  logic                 done;

  logic [1:0]           skid_cnt;
  logic                 skid_valid;
  logic                 skid_pop;
  logic [CMD_SIZE-1:0]  skid_dout;

  assign opcode    = bus.app_instr[CMD_SIZE-1 -: OPC_W];
  assign is_end    = (opcode == END_ISEQ);
  assign is_stop   = (opcode == STOP);
  assign stop_now  = (state_q == REPLAY) && bus.app_en && is_stop;
  assign last_rd   = ({1'b0, rd_ptr} == (len - LEN_W'(1)));
  assign iter_next = (&iter_cnt) ? iter_cnt : iter_cnt + ITER_W'(1);
  assign reached   = (loop_q != '0) && (iter_next == loop_q);
  // Skid entries plus the read in flight may never exceed the two skid slots,
  // so nothing is lost when the FIFO stalls.
  assign credit_ok = (({1'b0, skid_cnt} + {2'b00, inflight}) < 3'd2);

  always_comb begin
    state_d    = state_q;
    app_ack    = 1'b0;
    bram_we    = 1'b0;
    bram_waddr = '0;
    bram_re    = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.app_en) begin
          app_ack = 1'b1;
          bram_we = 1'b1;
          state_d = is_end ? REPLAY : FILL;
        end
      end
      FILL: begin
        if (bus.app_en) begin
          app_ack    = 1'b1;
          bram_we    = 1'b1;
          bram_waddr = wr_ptr;
          if (is_end)             state_d = REPLAY;
          else if (wr_ptr == '1)  state_d = IDLE;
        end
      end
      REPLAY: begin
        app_ack = stop_now;
        if (credit_ok) begin
          bram_re = 1'b1;
          if (last_rd && (reached || stop_pend || stop_now)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((skid_cnt == 2'd0) && !inflight) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      len       <= '0;
      iter_cnt  <= '0;
      loop_q    <= '0;
      overflow  <= 1'b0;
      stop_pend <= 1'b0;
      inflight  <= 1'b0;
    end else begin
      state_q  <= state_d;
      inflight <= bram_re;
      case (state_q)
        IDLE: begin
          if (bus.app_en) begin
            loop_q    <= bus.loop_count;
            overflow  <= 1'b0;
            rd_ptr    <= '0;
            iter_cnt  <= '0;
            stop_pend <= 1'b0;
            if (is_end) len    <= LEN_W'(1);
            else        wr_ptr <= ADDR_SIZE'(1);
          end
        end
        FILL: begin
          if (bus.app_en) begin
            wr_ptr <= wr_ptr + ADDR_SIZE'(1);
            if (is_end)            len      <= {1'b0, wr_ptr} + LEN_W'(1);
            else if (wr_ptr == '1) overflow <= 1'b1;
          end
        end
        REPLAY: begin
          if (stop_now) stop_pend <= 1'b1;
          if (bram_re) begin
            rd_ptr <= last_rd ? '0 : rd_ptr + ADDR_SIZE'(1);
            if (last_rd) iter_cnt <= iter_next;
          end
        end
        default: ;
      endcase
    end
  end

  loop_skid_buf #(.W(CMD_SIZE)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   (bus.bram_rdata),
    .pop   (skid_pop),
    .dout  (skid_dout),
    .valid (skid_valid),
    .count (skid_cnt)
  );

  assign skid_pop       = skid_valid && bus.out_ready;

  assign bus.app_ack    = app_ack;
  assign bus.bram_we    = bram_we;
  assign bus.bram_waddr = bram_waddr;
  assign bus.bram_wdata = bram_we ? bus.app_instr : '0;
  assign bus.bram_re    = bram_re;
  assign bus.bram_raddr = bram_re ? rd_ptr : '0;
  assign bus.out_valid  = skid_valid;
  assign bus.out_instr  = skid_valid ? skid_dout : '0;
  assign bus.looping    = (state_q == REPLAY) || (state_q == DRAIN);
  assign bus.iter_cnt   = iter_cnt;
  assign bus.done       = done;
  assign bus.overflow   = overflow;

endmodule

// File: tb/tb_instr_loop_sched.sv
// Randomized bench for instr_loop_sched: a queue-based reference model expects
// each loaded program repeated loop_count times (or whole iterations until STOP).
module tb_instr_loop_sched;
  import instr_loop_sched_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned CW = 32;
  localparam int unsigned IW = 16;

  typedef logic [CW-1:0] prog_t [$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_loop_sched_if #(.ADDR_SIZE(AW), .CMD_SIZE(CW), .ITER_W(IW)) bus ();

  instr_loop_sched #(.ADDR_SIZE(AW), .CMD_SIZE(CW), .ITER_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural dual-port BRAM with one-cycle read latency.
  logic [CW-1:0] bram [1 << AW];
  always @(posedge clk) begin
    if (bus.bram_we) bram[bus.bram_waddr] <= bus.bram_wdata;
    if (bus.bram_re) bus.bram_rdata <= bram[bus.bram_raddr];
  end

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Output monitor: sampled on the falling edge, away from the active edge.
  prog_t       got;
  int unsigned done_total  = 0;
  int unsigned valid_total = 0;
  int unsigned issued      = 0;
  int unsigned consumed    = 0;
  int unsigned max_outst   = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      consumed <= issued;
    end else begin
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_instr);
      if (bus.out_valid) valid_total <= valid_total + 1;
      if (bus.done)      done_total  <= done_total + 1;
      issued   <= issued + 32'(bus.bram_re);
      consumed <= consumed + 32'(bus.out_valid && bus.out_ready);
      if ((issued + 32'(bus.bram_re)) - (consumed + 32'(bus.out_valid && bus.out_ready)) > max_outst)
        max_outst <= (issued + 32'(bus.bram_re)) - (consumed + 32'(bus.out_valid && bus.out_ready));
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] rand_instr();
    logic [3:0] op;
    op = 4'($urandom_range(1, 14));
    return {op, 28'($urandom)};
  endfunction

  function automatic prog_t make_prog(input int unsigned len);
    prog_t p;
    for (int unsigned i = 0; i + 1 < len; i++) p.push_back(rand_instr());
    p.push_back({END_ISEQ, 28'($urandom)});
    return p;
  endfunction

  task automatic drive_ready(input int unsigned mode);
    case (mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic load_prog(input prog_t p, input logic [IW-1:0] loops);
    bus.loop_count = loops;
    foreach (p[i]) begin
      bus.app_en    = 1'b1;
      bus.app_instr = p[i];
      @(negedge clk);
      check_eq("load_ack", bus.app_ack, 1);
      check_eq("load_waddr", bus.bram_waddr, i);
      check_eq("load_wdata", bus.bram_wdata, p[i]);
      tick();
    end
    bus.app_en    = 1'b0;
    bus.app_instr = '0;
  endtask

  task automatic wait_done(input int unsigned mode, input int unsigned base_done);
    int unsigned cyc = 0;
    while (done_total == base_done && cyc < 3000) begin
      drive_ready(mode);
      tick();
      cyc++;
    end
  endtask

  task automatic check_stream(input string tag, input prog_t p, input int unsigned base,
                              input int unsigned n_exp);
    check_eq({tag, "_count"}, got.size() - base, n_exp);
    for (int unsigned i = 0; i < n_exp && base + i < got.size(); i++)
      check_eq({tag, "_data"}, got[base + i], p[i % p.size()]);
  endtask

  task automatic run_prog(input string tag, input prog_t p, input int unsigned loops,
                          input int unsigned mode);
    int unsigned base = got.size();
    int unsigned bd   = done_total;
    load_prog(p, IW'(loops));
    check_eq({tag, "_ovf_clear"}, bus.overflow, 0);
    wait_done(mode, bd);
    check_eq({tag, "_done"}, done_total - bd, 1);
    check_eq({tag, "_looping_low"}, bus.looping, 0);
    check_eq({tag, "_iter_cnt"}, bus.iter_cnt, loops);
    repeat (3) tick();
    check_eq({tag, "_single_done"}, done_total - bd, 1);
    check_eq({tag, "_iter_held"}, bus.iter_cnt, loops);
    check_stream(tag, p, base, p.size() * loops);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    prog_t p;
    int unsigned base, bd, n, vt, cyc;

    bus.app_en     = 1'b0;
    bus.app_instr  = '0;
    bus.loop_count = '0;
    bus.out_ready  = 1'b0;
    repeat (2) tick();

    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_looping", bus.looping, 0);
    check_eq("rst_iter_cnt", bus.iter_cnt, 0);
    check_eq("rst_bram_re", bus.bram_re, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_overflow", bus.overflow, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 3 + END, three iterations, FIFO always ready; then same program stalling.
    p = make_prog(4);
    run_prog("basic", p, 3, 0);
    run_prog("toggle", p, 3, 1);

    // Single END_ISEQ program goes straight from IDLE to REPLAY.
    p = make_prog(1);
    run_prog("single_end", p, 2, 0);

    // Full-capacity program (END at the last address).
    p = make_prog(1 << AW);
    run_prog("full_cap", p, 2, 2);

    // Infinite mode stopped by host STOP mid-iteration.
    p    = make_prog(4);
    base = got.size();
    bd   = done_total;
    load_prog(p, '0);
    cyc = 0;
    while (got.size() - base < 22 && cyc < 500) begin
      bus.out_ready = 1'b1;
      tick();
      cyc++;
    end
    check_eq("stop_reached_iter5", got.size() - base >= 22, 1);
    bus.app_en    = 1'b1;
    bus.app_instr = rand_instr();
    @(negedge clk);
    check_eq("replay_other_nack", bus.app_ack, 0);
    check_eq("replay_other_no_we", bus.bram_we, 0);
    tick();
    bus.app_instr = {STOP, 28'($urandom)};
    @(negedge clk);
    check_eq("stop_ack", bus.app_ack, 1);
    tick();
    bus.app_en = 1'b0;
    wait_done(0, bd);
    repeat (3) tick();
    n = got.size() - base;
    check_eq("stop_single_done", done_total - bd, 1);
    check_eq("stop_whole_iters", n % 4, 0);
    check_eq("stop_min_iters", n >= 24, 1);
    check_eq("stop_iter_cnt", bus.iter_cnt, n / 4);
    check_stream("stop", p, base, n);

    // Overflow: 2**ADDR_SIZE instructions without END_ISEQ.
    vt = valid_total;
    p.delete();
    for (int unsigned i = 0; i < (1 << AW); i++) p.push_back(rand_instr());
    load_prog(p, IW'(1));
    check_eq("ovf_set", bus.overflow, 1);
    check_eq("ovf_idle", bus.looping, 0);
    repeat (8) begin
      bus.out_ready = 1'b1;
      tick();
    end
    check_eq("ovf_no_valid", valid_total - vt, 0);
    check_eq("ovf_sticky", bus.overflow, 1);
    p = make_prog(3);
    run_prog("after_ovf", p, 1, 0);

    // Async reset while the skid is full and the FIFO is stalled.
    p = make_prog(4);
    bus.out_ready = 1'b0;
    load_prog(p, '0);
    repeat (6) tick();
    check_eq("pre_rst_valid", bus.out_valid, 1);
    check_eq("pre_rst_looping", bus.looping, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", bus.out_valid, 0);
    check_eq("arst_out_instr", bus.out_instr, 0);
    check_eq("arst_looping", bus.looping, 0);
    check_eq("arst_bram_re", bus.bram_re, 0);
    check_eq("arst_iter_cnt", bus.iter_cnt, 0);
    check_eq("arst_done", bus.done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    p = make_prog(5);
    run_prog("post_rst", p, 2, 0);

    // Random programs, loop counts and FIFO backpressure.
    for (int unsigned r = 0; r < 6; r++) begin
      p = make_prog($urandom_range(1, 1 << AW));
      run_prog("rand", p, $urandom_range(1, 4), $urandom_range(0, 2));
    end

    check_eq("max_outstanding_le2", max_outst <= 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
